// File: rtl/tx_axis_frame_arbiter.sv
// Frame-locked round-robin arbiter that shares one AXIS slave among NUM_PORTS requesters.
// Optional macro TX_ARB_STRICT_PRIO_EN gives port 0 strict priority when arbitrating.
module tx_axis_frame_arbiter #(
  parameter int unsigned NUM_PORTS       = 2,
  parameter int unsigned AXIS_DATA_WIDTH = 32,
  parameter int unsigned AXIS_DATA_BYTES = AXIS_DATA_WIDTH / 8,
  parameter int unsigned PTR_WIDTH       = $clog2(NUM_PORTS)
) (
  input  logic                                 tx_clk,
  input  logic                                 tx_rst,
  input  logic [NUM_PORTS*AXIS_DATA_WIDTH-1:0] in_slave_tx_tdata,
  input  logic [NUM_PORTS*AXIS_DATA_BYTES-1:0] in_slave_tx_tkeep,
  input  logic [NUM_PORTS-1:0]                 in_slave_tx_tvalid,
  input  logic [NUM_PORTS-1:0]                 in_slave_tx_tlast,
  output logic [NUM_PORTS-1:0]                 out_slave_tx_tready,
  output logic [AXIS_DATA_WIDTH-1:0]           out_master_tx_tdata,
  output logic [AXIS_DATA_BYTES-1:0]           out_master_tx_tkeep,
  output logic                                 out_master_tx_tvalid,
  output logic                                 out_master_tx_tlast,
  input  logic                                 in_master_tx_tready,
  output logic [PTR_WIDTH-1:0]                 out_grant_idx,
  output logic                                 out_busy
);

  typedef enum logic [0:0] {StIdle, StLock} state_e;

  state_e                     state_q, state_d;
  logic [PTR_WIDTH-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PTR_WIDTH-1:0]       grant_q, grant_d;
  logic [AXIS_DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [AXIS_DATA_BYTES-1:0] tkeep_q, tkeep_d;
  logic                       tvalid_q, tvalid_d;
  logic                       tlast_q, tlast_d;

  logic [AXIS_DATA_WIDTH-1:0] sel_tdata;
  logic [AXIS_DATA_BYTES-1:0] sel_tkeep;
  logic                       sel_tvalid;
  logic                       sel_tlast;
  logic                       win_found;
  logic [PTR_WIDTH-1:0]       win_idx;
  logic [PTR_WIDTH-1:0]       scan_idx;
  int unsigned                scan_pos;
  logic [PTR_WIDTH-1:0]       ptr_inc;
  logic                       slave_ready;
  logic                       beat;

  // Select the granted port's beat.
  always_comb begin
    sel_tdata  = '0;
    sel_tkeep  = '0;
    sel_tvalid = 1'b0;
    sel_tlast  = 1'b0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (grant_q == PTR_WIDTH'(p)) begin
        sel_tdata  = in_slave_tx_tdata[p*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
        sel_tkeep  = in_slave_tx_tkeep[p*AXIS_DATA_BYTES +: AXIS_DATA_BYTES];
        sel_tvalid = in_slave_tx_tvalid[p];
        sel_tlast  = in_slave_tx_tlast[p];
      end
    end
  end

  // Winner search starting at rr_ptr, wrapping modulo NUM_PORTS (works for non-power-of-two).
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_pos  = 0;
    scan_idx  = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      scan_pos = 32'(rr_ptr_q) + i;
      if (scan_pos >= NUM_PORTS) begin
        scan_pos = scan_pos - NUM_PORTS;
      end
      scan_idx = PTR_WIDTH'(scan_pos);
`ifdef TX_ARB_STRICT_PRIO_EN
      if (!win_found && (scan_pos != 0) && in_slave_tx_tvalid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
`else
      if (!win_found && in_slave_tx_tvalid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
`endif
    end
`ifdef TX_ARB_STRICT_PRIO_EN
    if (in_slave_tx_tvalid[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
    end
`endif
  end

  assign ptr_inc = (grant_q == PTR_WIDTH'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    tdata_d     = tdata_q;
    tkeep_d     = tkeep_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    slave_ready = 1'b0;
    beat        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          grant_d = win_idx;
          state_d = StLock;
        end
      end
      StLock: begin
        slave_ready = !tvalid_q || in_master_tx_tready;
        beat        = sel_tvalid && slave_ready;
      end
      default: state_d = StIdle;
    endcase

    // The output register drains independently of arbitration, even in StIdle.
    if (beat) begin
      tdata_d  = sel_tdata;
      tkeep_d  = sel_tkeep;
      tlast_d  = sel_tlast;
      tvalid_d = 1'b1;
      if (sel_tlast) begin
        state_d  = StIdle;
        rr_ptr_d = ptr_inc;
      end
    end else if (in_master_tx_tready) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge tx_clk or negedge tx_rst) begin
    if (!tx_rst) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
    end
  end

  assign out_slave_tx_tready  = slave_ready ? (NUM_PORTS'(1) << grant_q) : '0;
  assign out_master_tx_tdata  = tdata_q;
  assign out_master_tx_tkeep  = tkeep_q;
  assign out_master_tx_tvalid = tvalid_q;
  assign out_master_tx_tlast  = tlast_q;
  assign out_grant_idx        = grant_q;
  assign out_busy             = (state_q == StLock);

endmodule
